// File: rtl/mux4_1_arb.sv
// Four-lane to one-lane beat merger.
// Round-robin grant, held for a whole packet; registered output stage.
module mux4_1_arb #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     in_last,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [1:0]     out_sel,
  input  logic           out_ready
);

  typedef enum logic {
    ARB,
    LOCK
  } state_e;

  state_e         state_q;
  logic [1:0]     ptr_q;
  logic [1:0]     lk_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           out_last_q;
  logic [1:0]     out_sel_q;

  logic           load_en;
  logic           found;
  logic [1:0]     win;
  logic [1:0]     idx;
  logic [1:0]     sel;
  logic           grant;
  logic           hs;
  logic           sel_last;
  logic [W-1:0]   sel_data;

  assign load_en = !out_valid_q | out_ready;

  // First valid lane at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign sel   = (state_q == LOCK) ? lk_q : win;
  assign grant = (state_q == LOCK) | found;

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && grant && load_en)
      in_ready = 4'b0001 << sel;
  end

  assign hs       = |(in_ready & in_valid);
  assign sel_last = in_last[sel];

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 4; i++)
      if (sel == 2'(i))
        sel_data = in_data[i*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      ptr_q       <= 2'd0;
      lk_q        <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      if (hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_sel_q   <= sel;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        ARB: begin
          if (hs) begin
            if (sel_last) begin
              ptr_q <= sel + 2'd1;
            end else begin
              state_q <= LOCK;
              lk_q    <= sel;
            end
          end
        end
        LOCK: begin
          if (hs && sel_last) begin
            state_q <= ARB;
            ptr_q   <= lk_q + 2'd1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_1_arb.sv
// Directed bench for mux4_1_arb.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_mux4_1_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic [7:0]  d [4];

  int nchk = 0;
  int nerr = 0;

  assign in_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  mux4_1_arb #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag, input logic [3:0] exp);
    #1;
    check(tag, 32'(in_ready), 32'(exp));
  endtask

  task automatic beat(input string tag, input logic [1:0] s,
                      input logic [7:0] dt, input logic l);
    check({tag, ".v"}, 32'(out_valid), 32'd1);
    check({tag, ".sel"}, 32'(out_sel), 32'(s));
    check({tag, ".data"}, 32'(out_data), 32'(dt));
    check({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;

    // reset and idle
    cyc();
    rdy("rst_rdy", 4'b0000);
    check("rst_v", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    cyc();
    rdy("rst_rdy2", 4'b0000);
    rst_n    = 1'b1;
    in_valid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_v", 32'(out_valid), 32'd0);
      check("idle_rdy", 32'(in_ready), 32'd0);
    end

    // round robin with wrap
    in_valid = 4'hF;
    rdy("rr_rdy0", 4'b0001);
    for (int i = 0; i < 6; i++) begin
      cyc();
      beat("rr", 2'(i % 4), 8'hA0 + 8'(i % 4), 1'b1);
    end
    in_valid = 4'h0;
    cyc();
    check("rr_drain", 32'(out_valid), 32'd0);

    // packet lock on lane 2 (pointer now 2)
    d[0] = 8'h50; d[3] = 8'h53; d[2] = 8'h21;
    in_last  = 4'b1011;
    in_valid = 4'b1101;
    rdy("lk_rdy1", 4'b0100);
    cyc();
    beat("lk_b1", 2'd2, 8'h21, 1'b0);
    d[2] = 8'h22;
    rdy("lk_rdy2", 4'b0100);
    cyc();
    beat("lk_b2", 2'd2, 8'h22, 1'b0);
    d[2] = 8'h23;
    in_last = 4'b1111;
    cyc();
    beat("lk_b3", 2'd2, 8'h23, 1'b1);
    in_valid = 4'b1001;
    rdy("lk_rdy3", 4'b1000);
    cyc();
    beat("lk_l3", 2'd3, 8'h53, 1'b1);
    in_valid = 4'b0001;
    cyc();
    beat("lk_l0", 2'd0, 8'h50, 1'b1);
    in_valid = 4'h0;
    cyc();
    check("lk_drain", 32'(out_valid), 32'd0);

    // backpressure on lane 1 (pointer now 1)
    out_ready = 1'b0;
    d[1] = 8'h61;
    in_valid = 4'b0010;
    cyc();
    beat("bp_load", 2'd1, 8'h61, 1'b1);
    d[1] = 8'h62;
    for (int i = 0; i < 3; i++) begin
      rdy("bp_rdy", 4'b0000);
      cyc();
      beat("bp_hold", 2'd1, 8'h61, 1'b1);
    end
    out_ready = 1'b1;
    rdy("bp_rdy_go", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      beat("bp_flow", 2'd1, 8'h62 + 8'(i), 1'b1);
      d[1] = 8'h63 + 8'(i);
    end
    in_valid = 4'h0;
    cyc();
    check("bp_drain", 32'(out_valid), 32'd0);

    // lock with idle lane 0 (pointer now 2)
    d[0] = 8'h81; d[1] = 8'h71;
    in_last  = 4'b1110;
    in_valid = 4'b0011;
    rdy("id_rdy1", 4'b0001);
    cyc();
    beat("id_b1", 2'd0, 8'h81, 1'b0);
    in_valid = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      rdy("id_gap_rdy", 4'b0001);
      cyc();
      check("id_gap_v", 32'(out_valid), 32'd0);
    end
    d[0] = 8'h82;
    in_last  = 4'b1111;
    in_valid = 4'b0011;
    rdy("id_rdy2", 4'b0001);
    cyc();
    beat("id_b2", 2'd0, 8'h82, 1'b1);
    in_valid = 4'b0010;
    rdy("id_rdy3", 4'b0010);
    cyc();
    beat("id_l1", 2'd1, 8'h71, 1'b1);
    in_valid = 4'h0;
    cyc();

    // reset in the middle of a lane-3 packet (pointer now 2)
    d[3] = 8'h91;
    in_last  = 4'b0111;
    in_valid = 4'b1000;
    cyc();
    beat("rm_b1", 2'd3, 8'h91, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rm_v", 32'(out_valid), 32'd0);
    check("rm_sel", 32'(out_sel), 32'd0);
    check("rm_rdy", 32'(in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    d[0] = 8'hA5; d[3] = 8'h92;
    in_last  = 4'b1111;
    in_valid = 4'b1001;
    rdy("rm_rdy2", 4'b0001);
    cyc();
    beat("rm_l0", 2'd0, 8'hA5, 1'b1);
    in_valid = 4'b1000;
    cyc();
    beat("rm_l3", 2'd3, 8'h92, 1'b1);
    in_valid = 4'h0;
    cyc();
    check("rm_drain", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
